// File: rtl/vga_plot_mux.sv
// Plot multiplexer in front of the VGA adapter: forwards gameplay or banner
// pixels, and sweeps the screen to CLEAR_COLOUR when switching between them.
module vga_plot_mux #(
    parameter int         X_MAX        = 160,
    parameter int         Y_MAX        = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       over,
    input  logic       restart,
    input  logic [7:0] game_x,
    input  logic [6:0] game_y,
    input  logic [2:0] game_colour,
    input  logic       game_plot,
    input  logic [7:0] ban_x,
    input  logic [7:0] ban_y,
    input  logic [2:0] ban_colour,
    input  logic       ban_plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       clearing,
    output logic       clear_done,
    output logic       in_over
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
    localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);

    state_t     state_q, state_d;
    state_t     target_q, target_d;
    logic       over_prev_q, over_prev_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       clearing_q, clearing_d;
    logic       clear_done_q, clear_done_d;
    logic       in_over_q, in_over_d;

    logic       over_rise_s;
    logic       game_ok_s;
    logic       ban_ok_s;
    logic       start_s;
    logic       sweep_s;
    logic       last_s;
    logic [7:0] cur_x_s;
    logic [6:0] cur_y_s;

    assign over_rise_s = over & ~over_prev_q;
    assign game_ok_s   = game_plot && (32'(game_x) < X_MAX) && (32'(game_y) < Y_MAX);
    assign ban_ok_s    = ban_plot && (32'(ban_x) < X_MAX) && (32'(ban_y) < Y_MAX);

    // Next-state, sweep counter and registered-output computation.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        over_prev_d  = over;
        cx_d         = cx_q;
        cy_d         = cy_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        clearing_d   = 1'b0;
        clear_done_d = 1'b0;
        start_s      = 1'b0;
        sweep_s      = 1'b0;
        last_s       = 1'b0;
        cur_x_s      = cx_q;
        cur_y_s      = cy_q;

        case (state_q)
            ST_PLAY: begin
                if (over_rise_s) begin
                    start_s  = 1'b1;
                    target_d = ST_OVER;
                end else if (game_ok_s) begin
                    x_d      = game_x;
                    y_d      = game_y;
                    colour_d = game_colour;
                    plot_d   = 1'b1;
                end else begin
                    plot_d = 1'b0;
                end
            end
            ST_OVER: begin
                if (restart) begin
                    start_s  = 1'b1;
                    target_d = ST_PLAY;
                end else if (ban_ok_s) begin
                    x_d      = ban_x;
                    y_d      = ban_y[6:0];
                    colour_d = ban_colour;
                    plot_d   = 1'b1;
                end else begin
                    plot_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                sweep_s = 1'b1;
            end
            default: begin
                state_d  = ST_PLAY;
                target_d = ST_PLAY;
            end
        endcase

        // The entry cycle already emits pixel (0,0) so clearing lines up with plot.
        if (start_s) begin
            state_d = ST_CLEAR;
            sweep_s = 1'b1;
            cur_x_s = 8'd0;
            cur_y_s = 7'd0;
        end else begin
            cur_x_s = cx_q;
            cur_y_s = cy_q;
        end

        if (sweep_s) begin
            x_d        = cur_x_s;
            y_d        = cur_y_s;
            colour_d   = CLEAR_COLOUR;
            plot_d     = 1'b1;
            clearing_d = 1'b1;
            last_s     = (cur_x_s == X_LAST) && (cur_y_s == Y_LAST);
            if (last_s) begin
                clear_done_d = 1'b1;
                cx_d         = 8'd0;
                cy_d         = 7'd0;
                state_d      = target_q;
            end else if (cur_x_s == X_LAST) begin
                cx_d = 8'd0;
                cy_d = cur_y_s + 7'd1;
            end else begin
                cx_d = cur_x_s + 8'd1;
                cy_d = cur_y_s;
            end
        end else begin
            cx_d = cx_q;
            cy_d = cy_q;
        end

        in_over_d = (state_d == ST_OVER) && !sweep_s;
    end

    // State, edge-detect, counter and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_PLAY;
            target_q     <= ST_PLAY;
            over_prev_q  <= 1'b0;
            cx_q         <= 8'd0;
            cy_q         <= 7'd0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_q     <= 3'd0;
            plot_q       <= 1'b0;
            clearing_q   <= 1'b0;
            clear_done_q <= 1'b0;
            in_over_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            over_prev_q  <= over_prev_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            clearing_q   <= clearing_d;
            clear_done_q <= clear_done_d;
            in_over_q    <= in_over_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign clearing   = clearing_q;
    assign clear_done = clear_done_q;
    assign in_over    = in_over_q;

endmodule

// File: tb/tb_vga_plot_mux.sv
// Randomized bench for vga_plot_mux against a linear-pixel-index reference model.
module tb_vga_plot_mux;

    localparam int XM   = 160;
    localparam int YM   = 120;
    localparam int NPIX = XM * YM;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       over = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] game_x = 8'd0;
    logic [6:0] game_y = 7'd0;
    logic [2:0] game_colour = 3'd0;
    logic       game_plot = 1'b0;
    logic [7:0] ban_x = 8'd0;
    logic [7:0] ban_y = 8'd0;
    logic [2:0] ban_colour = 3'd0;
    logic       ban_plot = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       clearing;
    logic       clear_done;
    logic       in_over;

    int n_checks = 0;
    int n_pass   = 0;
    int sweep_cnt = 0;

    // Model: mode 0=PLAY 1=CLEAR 2=OVER; m_k is the linear index of the next clear pixel.
    int m_mode, m_target, m_prev, m_k;
    int e_x, e_y, e_col, e_plot, e_clr, e_done, e_inov;

    vga_plot_mux dut (
        .clock(clock), .reset(reset), .over(over), .restart(restart),
        .game_x(game_x), .game_y(game_y), .game_colour(game_colour), .game_plot(game_plot),
        .ban_x(ban_x), .ban_y(ban_y), .ban_colour(ban_colour), .ban_plot(ban_plot),
        .x(x), .y(y), .colour(colour), .plot(plot),
        .clearing(clearing), .clear_done(clear_done), .in_over(in_over)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_target = 0; m_prev = 0; m_k = 0;
        e_x = 0; e_y = 0; e_col = 0; e_plot = 0; e_clr = 0; e_done = 0; e_inov = 0;
    endtask

    task automatic emit_clear();
        e_x = m_k % XM; e_y = m_k / XM; e_col = 0; e_plot = 1; e_clr = 1;
        if (m_k == NPIX - 1) begin
            e_done = 1; m_mode = m_target; m_k = 0;
        end else begin
            m_k++;
        end
    endtask

    // Predicts the outputs that follow the next clock edge from the inputs now driven.
    task automatic model_step();
        int rise;
        rise = (over && m_prev == 0) ? 1 : 0;
        m_prev = over ? 1 : 0;
        e_plot = 0; e_clr = 0; e_done = 0;
        if (m_mode == 1) begin
            emit_clear();
        end else if (m_mode == 0 && rise == 1) begin
            m_mode = 1; m_target = 2; m_k = 0; emit_clear();
        end else if (m_mode == 2 && restart) begin
            m_mode = 1; m_target = 0; m_k = 0; emit_clear();
        end else if (m_mode == 0 && game_plot && int'(game_x) < XM && int'(game_y) < YM) begin
            e_x = int'(game_x); e_y = int'(game_y); e_col = int'(game_colour); e_plot = 1;
        end else if (m_mode == 2 && ban_plot && int'(ban_x) < XM && int'(ban_y) < YM) begin
            e_x = int'(ban_x); e_y = int'(ban_y); e_col = int'(ban_colour); e_plot = 1;
        end
        e_inov = (m_mode == 2 && e_clr == 0) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("plot", int'(plot), e_plot);
        check("x", int'(x), e_x);
        check("y", int'(y), e_y);
        check("colour", int'(colour), e_col);
        check("clearing", int'(clearing), e_clr);
        check("clear_done", int'(clear_done), e_done);
        check("in_over", int'(in_over), e_inov);
        if (plot && clearing) sweep_cnt++;
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic noise();
        game_x      = 8'($urandom_range(0, 199));
        game_y      = 7'($urandom_range(0, 127));
        game_colour = 3'($urandom);
        game_plot   = 1'($urandom);
        ban_x       = 8'($urandom_range(0, 199));
        ban_y       = 8'($urandom_range(0, 159));
        ban_colour  = 3'($urandom);
        ban_plot    = 1'($urandom);
    endtask

    initial begin
        int guard;
        model_reset();
        #1 reset = 1'b0;
        #2 compare_all();
        @(posedge clock); #1 compare_all();
        reset = 1'b1;

        // Directed gameplay pixel with a simultaneous banner pixel that must be dropped.
        game_plot = 1'b1; game_x = 8'd10; game_y = 7'd20; game_colour = 3'b101;
        ban_plot = 1'b1; ban_x = 8'd3; ban_y = 8'd3; ban_colour = 3'd7;
        step();
        for (int i = 0; i < 200; i++) begin
            noise(); over = 1'b0; restart = 1'($urandom); step();
        end

        // First sweep to OVER, with noise on every ignored input.
        sweep_cnt = 0;
        noise(); over = 1'b1; restart = 1'b0; step();
        for (int i = 1; i < NPIX; i++) begin
            noise(); over = 1'($urandom); restart = 1'($urandom); step();
        end
        check("sweep1_len", sweep_cnt, NPIX);
        noise(); game_plot = 1'b0; ban_plot = 1'b0; restart = 1'b0; step();

        // Banner forwarding and clipping in OVER.
        ban_plot = 1'b1; ban_x = 8'd5; ban_y = 8'd40; game_plot = 1'b0; step();
        ban_y = 8'd130; step();
        ban_plot = 1'b0; game_plot = 1'b1; game_x = 8'd5; game_y = 7'd5; step();
        for (int i = 0; i < 200; i++) begin
            noise(); over = 1'($urandom); restart = 1'b0; step();
        end

        // Restart together with a fresh over edge.
        noise(); over = 1'b0; step();
        sweep_cnt = 0;
        noise(); over = 1'b1; restart = 1'b1; step();
        for (int i = 1; i < NPIX; i++) begin
            noise(); over = 1'($urandom); restart = 1'($urandom); step();
        end
        check("sweep2_len", sweep_cnt, NPIX);
        for (int i = 0; i < 200; i++) begin
            noise(); over = 1'b0; restart = 1'($urandom); step();
        end

        // Third sweep, aborted by reset at pixel (37,50).
        noise(); over = 1'b1; restart = 1'b0; step();
        guard = 0;
        while (!(m_mode == 1 && m_k == 50 * XM + 37) && guard < NPIX) begin
            noise(); over = 1'($urandom); restart = 1'($urandom); step();
            guard++;
        end
        check("abort_reached", guard < NPIX ? 1 : 0, 1);
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        over = 1'b1;
        #2 reset = 1'b1;
        noise(); restart = 1'b0; step();
        check("restart_clear", int'(clearing), 1);
        for (int i = 0; i < 300; i++) begin
            noise(); restart = 1'($urandom); step();
        end

        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        over = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            noise(); restart = 1'($urandom); step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_plot_mux.md
Name: vga_plot_mux

Overview:
- Sits between the pixel producers and the VGA adapter.
- Passes gameplay sprite plots to the adapter during play.
- On game over, sweeps the whole screen to a clear colour, then passes only the game-over banner's plots.
- A restart request clears the screen again and returns to gameplay.
- All outputs are registered; one plot per clock maximum.

Parameters:
- X_MAX, 160, screen width in pixels; valid x range is 0..X_MAX-1.
- Y_MAX, 120, screen height in pixels; valid y range is 0..Y_MAX-1.
- CLEAR_COLOUR, 3'b000, colour written during a clear sweep.

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- over  in  1  game-over level; its rising edge starts the clear-to-banner sequence.
- restart  in  1  single-cycle request; honoured only in OVER.
- game_x  in  8  gameplay pixel x.
- game_y  in  7  gameplay pixel y.
- game_colour  in  3  gameplay pixel colour.
- game_plot  in  1  gameplay pixel valid.
- ban_x  in  8  banner pixel x.
- ban_y  in  8  banner pixel y; bit 7 must be 0 for the pixel to be in range.
- ban_colour  in  3  banner pixel colour.
- ban_plot  in  1  banner pixel valid.
- x  out  8  pixel x to the VGA adapter.
- y  out  7  pixel y to the VGA adapter.
- colour  out  3  pixel colour to the VGA adapter.
- plot  out  1  write enable to the VGA adapter.
- clearing  out  1  high while in CLEAR.
- clear_done  out  1  one-cycle pulse on the last clear pixel.
- in_over  out  1  high while in OVER.

Behaviour:
- Reset (async, reset=0):
  - state=PLAY, target=PLAY, over_d=0, sweep counters cx=cy=0.
  - Outputs x=0, y=0, colour=0, plot=0, clearing=0, clear_done=0, in_over=0.
- Edge detect: over_rise = over & ~over_d, with over_d registered every clock.
  - If over is already high when reset releases, over_rise fires on the first clock.
- States:
  - PLAY: over_rise -> CLEAR with target=OVER.
  - OVER: over_rise is ignored. restart -> CLEAR with target=PLAY.
  - CLEAR: the only exit is after the last pixel: state <= target.
- Mutual priority: over_rise beats restart in the same cycle. In OVER, over_rise is ignored, so restart is taken.
- CLEAR sweep, one pixel per clock:
  - Output x=cx, y=cy, colour=CLEAR_COLOUR, plot=1.
  - cx increments. At cx=X_MAX-1, cx wraps to 0 and cy increments.
  - At cx=X_MAX-1 and cy=Y_MAX-1: clear_done pulses with that pixel, counters return to 0, and state <= target.
  - Total duration is X_MAX*Y_MAX clocks (19200 at defaults). Counters are zeroed on entry to CLEAR.
- Inputs ignored during CLEAR: restart, over_rise, game_plot and ban_plot are all dropped, with no queuing.
- PLAY pass-through: the registered outputs take the game_* inputs one clock later (latency 1). ban_plot is dropped.
- OVER pass-through: the registered outputs take ban_x and ban_y[6:0] with ban_colour, latency 1. game_plot is dropped.
- Clipping: a source pixel with x >= X_MAX, or y >= Y_MAX (for the banner, the full 8-bit y is compared), produces plot=0. In that case x, y and colour hold their previous values.
- Idle behaviour: when no pixel is forwarded, plot=0 and x, y, colour hold.
- clearing and in_over are registered decodes of the next state, so they are aligned with the plot output they accompany.
- Reset mid-CLEAR: the sweep is aborted immediately and the block returns to PLAY. The screen contents are left partially cleared; no recovery is performed.

Test Plan:
- Reset, then drive game_plot=1, game_x=10, game_y=20, game_colour=3'b101 -> the next clock shows x=10, y=20, colour=5, plot=1. ban_plot=1 in the same cycle is dropped.
- Pulse over high -> clearing=1. Exactly 19200 plots follow with colour=0: first pixel (0,0), pixel 160 is (0,1), last pixel (159,119) coincides with clear_done=1. The next cycle has in_over=1.
- In OVER, drive ban_plot=1, ban_x=5, ban_y=8'd40 -> x=5, y=40, plot=1. With ban_y=8'd130 -> plot=0. With game_plot=1 -> plot=0.
- In OVER, pulse restart together with a new over rising edge -> CLEAR with target PLAY. After 19200 cycles in_over=0 and game plots pass through again.
- During CLEAR, toggle restart, ban_plot and game_plot -> the sweep sequence is unaltered and the final state equals the original target.
- Assert reset at sweep pixel (37,50) -> the same clock gives plot=0, clearing=0, state PLAY. After release with over held high, a new CLEAR starts on the first clock.
